limp_sequencer: RTL and testbench

- Parametrised multi-zone fertilise-then-flush sequencer. It is the successor of the single-channel ADB/LIMP controller in the irrigation FSM.
- On a fertilisation request it visits every enabled zone in ascending order. Each zone gets an injection (ADB) phase, then a clean-water flush (LIMP) phase, with programmable durations.
- It sits between the sensor inputs (tank low, valve supply, critical level) and the per-zone valve and injection pump drivers.
- It adds critical-level abort, supply-loss pause and a sticky fault state.

---
 rtl/limp_sequencer_if.sv | 38 +++
 rtl/limp_sequencer.sv | 146 ++++++++++++++
 tb/tb_limp_sequencer.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/limp_sequencer_if.sv
// Sensor, request and zone-drive bundle between the irrigation controller and limp_sequencer.
// LIMP_SEQ_DONE_CNT_EN adds the completed-sweep counter to the bundle.
interface limp_sequencer_if #(
   parameter int NZ = 4,
   parameter int ZW = ($clog2(NZ) < 1) ? 1 : $clog2(NZ)
);
   logic          adb;
   logic [NZ-1:0] zone_en;
   logic          low;
   logic          ve;
   logic          critico;
   logic          clr;
   logic [2:0]    state;
   logic [ZW-1:0] zone;
   logic [NZ-1:0] valve;
   logic          inj;
   logic          busy;
   logic          fault;
`ifdef LIMP_SEQ_DONE_CNT_EN
   logic [15:0]   done_cnt;
`endif

   modport master (
      output adb, zone_en, low, ve, critico, clr,
`ifdef LIMP_SEQ_DONE_CNT_EN
      input  done_cnt,
`endif
      input  state, zone, valve, inj, busy, fault
   );

   modport slave (
      input  adb, zone_en, low, ve, critico, clr,
`ifdef LIMP_SEQ_DONE_CNT_EN
      output done_cnt,
`endif
      output state, zone, valve, inj, busy, fault
   );
endinterface

// File: rtl/limp_sequencer.sv
// Multi-zone fertilise (ADB) then flush (LIMP) sequencer with supply pause, critical abort and sticky fault.
// Optional completed-sweep counter enabled by defining LIMP_SEQ_DONE_CNT_EN.
module limp_sequencer #(
   parameter int NZ     = 4,
   parameter int CW     = 8,
   parameter int FERT_T = 20,
   parameter int LIMP_T = 10
) (
   input logic             clock,
   input logic             resetN,
   limp_sequencer_if.slave bus
);
   localparam int ZW = ($clog2(NZ) < 1) ? 1 : $clog2(NZ);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SCAN  = 3'd1;
   localparam logic [2:0] S_ADB   = 3'd2;
   localparam logic [2:0] S_LIMP  = 3'd3;
   localparam logic [2:0] S_NEXT  = 3'd4;
   localparam logic [2:0] S_FAULT = 3'd5;

   localparam logic [CW-1:0] FERT_LOAD = CW'(FERT_T - 1);
   localparam logic [CW-1:0] LIMP_LOAD = CW'(LIMP_T - 1);
   localparam logic [ZW-1:0] LAST_ZONE = ZW'(NZ - 1);

   logic [2:0]    state_reg, state_next;
   logic [ZW-1:0] zone_reg, zone_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [NZ-1:0] valve_bits;

   always_comb begin
      state_next = state_reg;
      zone_next  = zone_reg;
      cnt_next   = cnt_reg;
      if (bus.critico && state_reg != S_FAULT) begin
         state_next = S_FAULT;
         zone_next  = '0;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (bus.adb && bus.ve && !bus.low && |bus.zone_en) begin
                  state_next = S_SCAN;
                  zone_next  = '0;
               end
            end
            S_SCAN: begin
               if (bus.zone_en[zone_reg]) begin
                  state_next = S_ADB;
                  cnt_next   = FERT_LOAD;
               end else begin
                  state_next = S_NEXT;
               end
            end
            S_ADB: begin
               // A dry tank cuts injection short but the zone is still flushed.
               if (bus.low) begin
                  state_next = S_LIMP;
                  cnt_next   = LIMP_LOAD;
               end else if (bus.ve) begin
                  if (cnt_reg == '0) begin
                     state_next = S_LIMP;
                     cnt_next   = LIMP_LOAD;
                  end else begin
                     cnt_next = cnt_reg - 1'b1;
                  end
               end
            end
            S_LIMP: begin
               if (bus.ve) begin
                  if (cnt_reg == '0) begin
                     state_next = S_NEXT;
                  end else begin
                     cnt_next = cnt_reg - 1'b1;
                  end
               end
            end
            S_NEXT: begin
               if (zone_reg == LAST_ZONE) begin
                  state_next = S_IDLE;
                  zone_next  = '0;
               end else begin
                  state_next = S_SCAN;
                  zone_next  = zone_reg + 1'b1;
               end
            end
            S_FAULT: begin
               zone_next = '0;
               cnt_next  = '0;
               if (bus.clr && !bus.critico) begin
                  state_next = S_IDLE;
               end
            end
            default: begin
               state_next = S_IDLE;
               zone_next  = '0;
               cnt_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge resetN) begin
      if (resetN) begin
         state_reg <= S_IDLE;
         zone_reg  <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         zone_reg  <= zone_next;
         cnt_reg   <= cnt_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NZ; gi++) begin : g_valve
         assign valve_bits[gi] = (state_reg == S_ADB || state_reg == S_LIMP) &&
                                 (zone_reg == ZW'(gi));
      end
   endgenerate

   assign bus.state = state_reg;
   assign bus.zone  = zone_reg;
   assign bus.valve = valve_bits;
   // Injection follows supply so a supply dip pauses the pump without leaving ADB.
   assign bus.inj   = (state_reg == S_ADB) && bus.ve;
   assign bus.busy  = (state_reg == S_SCAN) || (state_reg == S_ADB) ||
                      (state_reg == S_LIMP) || (state_reg == S_NEXT);
   assign bus.fault = (state_reg == S_FAULT);

`ifdef LIMP_SEQ_DONE_CNT_EN
   logic [15:0] done_cnt_reg;

   always_ff @(posedge clock or posedge resetN) begin
      if (resetN) begin
         done_cnt_reg <= '0;
      end else if (!bus.critico && state_reg == S_NEXT && zone_reg == LAST_ZONE &&
                   done_cnt_reg != 16'hFFFF) begin
         done_cnt_reg <= done_cnt_reg + 16'd1;
      end
   end

   assign bus.done_cnt = done_cnt_reg;
`endif
endmodule

// File: tb/tb_limp_sequencer.sv
// Randomised sweeps against a phase-list model of the sequencer, plus directed pause, dry-tank, abort and reset scenarios.
module tb_limp_sequencer;
   localparam int NZ     = 4;
   localparam int CW     = 8;
   localparam int FERT_T = 20;
   localparam int LIMP_T = 10;
   localparam int ZW     = ($clog2(NZ) < 1) ? 1 : $clog2(NZ);
   localparam int OW     = 3 + ZW + NZ + 3;
   localparam int MAXK   = 1024;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SCAN  = 3'd1;
   localparam logic [2:0] ST_ADB   = 3'd2;
   localparam logic [2:0] ST_LIMP  = 3'd3;
   localparam logic [2:0] ST_NEXT  = 3'd4;
   localparam logic [2:0] ST_FAULT = 3'd5;

   logic clock  = 1'b0;
   logic resetN = 1'b1;
   int   checks = 0;
   int   errors = 0;

   limp_sequencer_if #(.NZ(NZ)) bus ();

   limp_sequencer #(.NZ(NZ), .CW(CW), .FERT_T(FERT_T), .LIMP_T(LIMP_T)) dut (
      .clock (clock),
      .resetN(resetN),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [OW-1:0] outs();
      return {bus.state, bus.zone, bus.valve, bus.inj, bus.busy, bus.fault};
   endfunction

   task automatic set_inputs(input logic adb, input logic [NZ-1:0] en, input logic ve,
                             input logic low, input logic critico, input logic clr);
      bus.adb     = adb;
      bus.zone_en = en;
      bus.ve      = ve;
      bus.low     = low;
      bus.critico = critico;
      bus.clr     = clr;
   endtask

   task automatic do_reset();
      resetN = 1'b1;
      set_inputs(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clock);
      resetN = 1'b0;
      @(negedge clock);
   endtask

   // Leaves the bench at the negedge of the first SCAN cycle.
   task automatic start_sweep(input logic [NZ-1:0] en, input logic hold_adb);
      set_inputs(1'b1, en, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      bus.adb = hold_adb;
   endtask

   task automatic wait_state(input logic [2:0] st, input int zn, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus.state == st && (zn < 0 || int'(bus.zone) == zn)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      set_inputs(1'b1, '1, 1'b1, 1'b0, 1'b1, 1'b1);
      resetN = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      #1;
      checks++;
      if (outs() !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h want %h", outs(), {OW{1'b0}});
      end
      set_inputs(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      resetN = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_release_state got %0d want %0d", bus.state, ST_IDLE);
      end
`ifdef LIMP_SEQ_DONE_CNT_EN
      checks++;
      if (bus.done_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_done_cnt got %0d want 0", bus.done_cnt);
      end
`endif
   endtask

   task automatic test_random_sweeps();
      bit            ve_vec[MAXK];
      logic [2:0]    es[$];
      int            ez[$];
      logic [NZ-1:0] en;
      logic [NZ-1:0] ev;
      logic [OW-1:0] exp_o;
      int            k;
      int            n;
      for (int it = 0; it < 8; it++) begin
         if (it == 0)      en = NZ'(1);
         else if (it == 1) en = NZ'(4'b1010);
         else              en = NZ'($urandom_range(1, (1 << NZ) - 1));
         for (int i = 0; i < MAXK; i++)
            ve_vec[i] = (it < 2 || i >= 600) ? 1'b1 : ($urandom_range(0, 3) != 0);
         // A phase ends on the cycle that supplies its last ve-high tick.
         es.delete();
         ez.delete();
         k = 0;
         for (int z = 0; z < NZ; z++) begin
            es.push_back(ST_SCAN); ez.push_back(z); k++;
            if (en[z]) begin
               n = 0;
               while (n < FERT_T) begin
                  es.push_back(ST_ADB); ez.push_back(z);
                  if (ve_vec[k]) n++;
                  k++;
               end
               n = 0;
               while (n < LIMP_T) begin
                  es.push_back(ST_LIMP); ez.push_back(z);
                  if (ve_vec[k]) n++;
                  k++;
               end
            end
            es.push_back(ST_NEXT); ez.push_back(z); k++;
         end
         do_reset();
         start_sweep(en, 1'b0);
         for (int c = 0; c < es.size(); c++) begin
            bus.ve = ve_vec[c];
            #1;
            ev = (es[c] == ST_ADB || es[c] == ST_LIMP) ? (NZ'(1) << ez[c]) : '0;
            exp_o = {es[c], ZW'(ez[c]), ev, (es[c] == ST_ADB) && ve_vec[c],
                     (es[c] != ST_IDLE && es[c] != ST_FAULT), 1'b0};
            checks++;
            if (outs() !== exp_o) begin
               errors++;
               $display("FAIL sweep it=%0d en=%b cycle=%0d got %h want %h",
                        it, en, c, outs(), exp_o);
            end
            @(negedge clock);
         end
         bus.ve = 1'b1;
         #1;
         checks++;
         if (bus.state !== ST_IDLE || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL sweep_end it=%0d got state=%0d busy=%b want state=0 busy=0",
                     it, bus.state, bus.busy);
         end
      end
   endtask

   task automatic test_supply_loss();
      bit ok;
      int n;
      int m;
      do_reset();
      start_sweep(NZ'(1), 1'b0);
      wait_state(ST_ADB, 0, 5, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL supply_enter_adb got state=%0d want %0d", bus.state, ST_ADB);
      end
      n = 0;
      while (bus.state == ST_ADB && n < 100) begin
         n++;
         bus.ve = (n >= 7 && n <= 11) ? 1'b0 : 1'b1;
         #1;
         checks++;
         if (bus.inj !== bus.ve || bus.valve !== NZ'(1)) begin
            errors++;
            $display("FAIL supply_adb_cycle%0d got inj=%b valve=%b want inj=%b valve=%b",
                     n, bus.inj, bus.valve, bus.ve, NZ'(1));
         end
         @(negedge clock);
      end
      bus.ve = 1'b1;
      checks++;
      if (n !== FERT_T + 5) begin
         errors++;
         $display("FAIL supply_adb_length got %0d want %0d", n, FERT_T + 5);
      end
      m = 0;
      while (bus.state == ST_LIMP && m < 100) begin
         m++;
         @(negedge clock);
      end
      checks++;
      if (m !== LIMP_T) begin
         errors++;
         $display("FAIL supply_limp_length got %0d want %0d", m, LIMP_T);
      end
      wait_state(ST_IDLE, -1, 20, ok);
   endtask

   task automatic test_dry_tank();
      bit ok;
      int n;
      int m;
      do_reset();
      start_sweep(NZ'(4'b0011), 1'b0);
      wait_state(ST_ADB, 0, 5, ok);
      n = 0;
      while (bus.state == ST_ADB && n < 100) begin
         n++;
         bus.low = (n == 4);
         @(negedge clock);
      end
      bus.low = 1'b0;
      checks++;
      if (n !== 4) begin
         errors++;
         $display("FAIL dry_adb_length got %0d want 4", n);
      end
      #1;
      checks++;
      if (bus.state !== ST_LIMP || bus.inj !== 1'b0 || bus.valve !== NZ'(1)) begin
         errors++;
         $display("FAIL dry_to_limp got state=%0d inj=%b valve=%b want state=3 inj=0 valve=%b",
                  bus.state, bus.inj, bus.valve, NZ'(1));
      end
      m = 0;
      while (bus.state == ST_LIMP && m < 100) begin
         m++;
         @(negedge clock);
      end
      checks++;
      if (m !== LIMP_T) begin
         errors++;
         $display("FAIL dry_limp_length got %0d want %0d", m, LIMP_T);
      end
      wait_state(ST_ADB, 1, 10, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL dry_next_zone got state=%0d zone=%0d want state=2 zone=1",
                  bus.state, bus.zone);
      end
      wait_state(ST_IDLE, -1, 100, ok);
   endtask

   task automatic test_zone_en_hold();
      bit ok;
      int n;
      do_reset();
      start_sweep(NZ'(1), 1'b0);
      wait_state(ST_ADB, 0, 5, ok);
      n = 0;
      while (bus.state == ST_ADB && n < 100) begin
         n++;
         if (n == 3) bus.zone_en = '0;
         @(negedge clock);
      end
      checks++;
      if (n !== FERT_T) begin
         errors++;
         $display("FAIL zone_en_hold_adb_length got %0d want %0d", n, FERT_T);
      end
      wait_state(ST_IDLE, -1, 60, ok);
   endtask

   task automatic test_critical();
      bit ok;
      do_reset();
      start_sweep(NZ'(4'b0111), 1'b0);
      wait_state(ST_LIMP, 2, 200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL crit_reach_limp2 got state=%0d zone=%0d want state=3 zone=2",
                  bus.state, bus.zone);
      end
      repeat (3) @(negedge clock);
      bus.critico = 1'b1;
      @(negedge clock);
      #1;
      checks++;
      if (outs() !== {ST_FAULT, {ZW{1'b0}}, {NZ{1'b0}}, 3'b001}) begin
         errors++;
         $display("FAIL crit_abort got %h want %h", outs(),
                  {ST_FAULT, {ZW{1'b0}}, {NZ{1'b0}}, 3'b001});
      end
      bus.clr = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if (bus.state !== ST_FAULT) begin
         errors++;
         $display("FAIL crit_clr_blocked got state=%0d want %0d", bus.state, ST_FAULT);
      end
      bus.clr     = 1'b0;
      bus.critico = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.state !== ST_FAULT || bus.fault !== 1'b1) begin
         errors++;
         $display("FAIL crit_sticky got state=%0d fault=%b want 5 1", bus.state, bus.fault);
      end
      bus.clr = 1'b1;
      @(negedge clock);
      bus.clr = 1'b0;
      checks++;
      if (bus.state !== ST_IDLE || bus.fault !== 1'b0) begin
         errors++;
         $display("FAIL crit_clear got state=%0d fault=%b want 0 0", bus.state, bus.fault);
      end
      bus.critico = 1'b1;
      @(negedge clock);
      bus.critico = 1'b0;
      checks++;
      if (bus.state !== ST_FAULT) begin
         errors++;
         $display("FAIL crit_from_idle got state=%0d want %0d", bus.state, ST_FAULT);
      end
      bus.clr = 1'b1;
      @(negedge clock);
      bus.clr = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n;
      do_reset();
      start_sweep(NZ'(1), 1'b1);
      n = 0;
      while (bus.busy && n < 200) begin
         n++;
         @(negedge clock);
      end
      checks++;
      if (n !== 1 + FERT_T + LIMP_T + 1 + 2 * (NZ - 1) || bus.state !== ST_IDLE) begin
         errors++;
         $display("FAIL b2b_sweep got cycles=%0d state=%0d want cycles=%0d state=0",
                  n, bus.state, 1 + FERT_T + LIMP_T + 1 + 2 * (NZ - 1));
      end
      @(negedge clock);
      bus.adb = 1'b0;
      checks++;
      if (bus.state !== ST_SCAN || bus.zone !== '0) begin
         errors++;
         $display("FAIL b2b_restart got state=%0d zone=%0d want 1 0", bus.state, bus.zone);
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      do_reset();
      start_sweep(NZ'(1), 1'b0);
      wait_state(ST_ADB, 0, 5, ok);
      repeat (5) @(negedge clock);
      #2;
      resetN = 1'b1;
      #1;
      checks++;
      if (outs() !== '0) begin
         errors++;
         $display("FAIL async_reset got %h want %h", outs(), {OW{1'b0}});
      end
      bus.critico = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (bus.state !== ST_IDLE || bus.fault !== 1'b0) begin
         errors++;
         $display("FAIL reset_beats_critico got state=%0d fault=%b want 0 0",
                  bus.state, bus.fault);
      end
      bus.critico = 1'b0;
      @(negedge clock);
      resetN = 1'b0;
      @(negedge clock);
   endtask

`ifdef LIMP_SEQ_DONE_CNT_EN
   task automatic test_done_cnt();
      bit ok;
      int sweeps;
      do_reset();
      sweeps = 0;
      for (int s = 0; s < 3; s++) begin
         start_sweep(NZ'(1), 1'b0);
         wait_state(ST_IDLE, -1, 100, ok);
         if (ok) sweeps++;
      end
      checks++;
      if (bus.done_cnt !== 16'(sweeps) || sweeps != 3) begin
         errors++;
         $display("FAIL done_cnt_sweeps got %0d want 3", bus.done_cnt);
      end
      start_sweep(NZ'(1), 1'b0);
      wait_state(ST_ADB, 0, 5, ok);
      bus.critico = 1'b1;
      @(negedge clock);
      bus.critico = 1'b0;
      bus.clr     = 1'b1;
      @(negedge clock);
      bus.clr = 1'b0;
      checks++;
      if (bus.done_cnt !== 16'd3 || bus.state !== ST_IDLE) begin
         errors++;
         $display("FAIL done_cnt_abort got cnt=%0d state=%0d want 3 0", bus.done_cnt, bus.state);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_random_sweeps();
      test_supply_loss();
      test_dry_tank();
      test_zone_en_hold();
      test_critical();
      test_back_to_back();
      test_async_reset();
`ifdef LIMP_SEQ_DONE_CNT_EN
      test_done_cnt();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
